mont_modexp_ctrl: RTL and testbench
===================================

Name: mont_modexp_ctrl

Overview:
Sequencer for modular exponentiation, result = x^e mod m, built on the bit-serial Montgomery multiplier (montprowrap).
- Drives that multiplier through a start/vld handshake and holds its operands.
- Sequence: convert x into the Montgomery domain, run left-to-right square-and-multiply-always over every exponent bit, then convert back out.
- Sits directly upstream of the multiplier and feeds it; also consumes its result.

Parameters:
WID, 256, operand/modulus width (must equal multiplier WID); R = 2^WID
EWID, 256, exponent width in bits
ECW, 8, exponent bit-index width = clog2(EWID)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin exponentiation; sampled only in IDLE
x  in  WID  base, must be < m
e  in  EWID  exponent
m  in  WID  modulus, odd, m > 1
rr  in  WID  R^2 mod m (precomputed)
one_m  in  WID  R mod m (Montgomery one)
busy  out  1  high from the cycle after accepted start until the done cycle, inclusive
done  out  1  single-cycle pulse; result valid
result  out  WID  registered x^e mod m; holds until next done
mp_start  out  1  single-cycle start pulse to multiplier
mp_a  out  WID  multiplier operand a
mp_b  out  WID  multiplier operand b
mp_m  out  WID  multiplier modulus
mp_r  in  WID  multiplier result, < m
mp_vld  in  1  multiplier result-valid pulse

Behaviour:
- Reset values: busy=0, done=0, mp_start=0, result=0, mp_a=mp_b=mp_m=0, state=IDLE.
- Start capture: start in IDLE latches x, e, m, rr, one_m into internal registers; later input changes are ignored. start while busy is ignored.
- Internal registers: acc (WID), xm (WID), tmp (WID), eidx (ECW), initialised to acc=one_m, eidx=EWID-1.
- Operation list, strictly in order:
  - CONV: xm = MP(x, rr)
  - Per bit eidx from EWID-1 down to 0:
    - SQR: acc = MP(acc, acc)
    - MUL: tmp = MP(acc, xm); acc = tmp if e[eidx]=1, else acc unchanged (dummy multiply keeps timing constant)
  - FINAL: result = MP(acc, 1)
- Operation count: exactly 2*EWID+2 multiplier operations, independent of e.
- Per-operation handshake (two substates):
  - ISSUE (1 cycle): mp_start=1, with mp_a/mp_b/mp_m already driven.
  - WAIT: mp_start=0; mp_a/mp_b/mp_m held stable until mp_vld.
  - mp_r is captured in the mp_vld cycle; the next op's ISSUE is the following cycle.
- mp_m = latched m for the whole run.
- mp_vld outside WAIT is ignored. mp_vld never arrives in the ISSUE cycle; this is asserted in the bench.
- eidx decrements after each MUL capture. eidx=0 MUL goes to FINAL; there is no wrap-around.
- Completion: the cycle after FINAL's mp_vld, result is registered, done=1 for 1 cycle, busy then drops and the state returns to IDLE.
- A start in the same cycle as done is ignored; a start one cycle later is accepted.
- Total latency, start to done = 1 + (2*EWID+2)*(1+Tmp) + 1 cycles, where Tmp is the multiplier's start-to-vld latency.
- e=0: all MULs discarded; result = 1.
- x=0: result = 0 for e≠0.
- Reset mid-operation: returns to IDLE next edge, no done pulse, mp_start low. The multiplier shares rst, so no stale vld is seen.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, CONV, SQR, MUL, FINAL, FIN_OUT, each with ISSUE/WAIT sub-flag
  - op-select constants for the operand mux
  - default WID/EWID
- No sub-module needed; operand mux, exponent index counter and FSM fit in one file.
- The integrating top instantiates this block and montprowrap side by side; that top is outside this spec.

Test Plan:
- TEST config WID=4, EWID=4, m=13, one_m=3, rr=9, against the real multiplier.
  - x=2, e=5 -> result=6, done exactly once, 10 mp_start pulses counted.
  - x=7, e=0 -> result=1; x=0, e=3 -> result=0; x=12, e=2 -> result=1.
- Timing: measure start-to-done for e=4'b0000 and e=4'b1111 -> identical cycle counts, equal to the latency formula.
- start pulsed again mid-run with different x -> ignored, first result correct. start in the done cycle -> ignored.
- Assert rst during the 3rd WAIT -> busy=0 and mp_start=0 next cycle, no done. A fresh start then completes correctly.
- Operand stability: check mp_a/mp_b/mp_m are constant from each mp_start through mp_vld. Randomised 256-bit run (odd m) vs reference model, 50 vectors.

Source files
------------

// File: rtl/mont_modexp_ctrl_pkg.sv
// Shared constants for the Montgomery modular-exponentiation sequencer.
package mont_modexp_ctrl_pkg;

  localparam int unsigned DEF_WID  = 256;
  localparam int unsigned DEF_EWID = 256;
  localparam int unsigned DEF_ECW  = 8;

  // State = {operation, sub-flag}; sub-flag distinguishes ISSUE from WAIT.
  localparam int unsigned OP_W = 3;
  localparam int unsigned ST_W = OP_W + 1;

  localparam logic [OP_W-1:0] OP_IDLE    = 3'd0;
  localparam logic [OP_W-1:0] OP_CONV    = 3'd1;
  localparam logic [OP_W-1:0] OP_SQR     = 3'd2;
  localparam logic [OP_W-1:0] OP_MUL     = 3'd3;
  localparam logic [OP_W-1:0] OP_FINAL   = 3'd4;
  localparam logic [OP_W-1:0] OP_FIN_OUT = 3'd5;

  localparam logic SUB_ISSUE = 1'b0;
  localparam logic SUB_WAIT  = 1'b1;

  localparam logic [ST_W-1:0] S_IDLE    = {OP_IDLE,    SUB_ISSUE};
  localparam logic [ST_W-1:0] S_LOAD    = {OP_IDLE,    SUB_WAIT};
  localparam logic [ST_W-1:0] S_CONV_I  = {OP_CONV,    SUB_ISSUE};
  localparam logic [ST_W-1:0] S_CONV_W  = {OP_CONV,    SUB_WAIT};
  localparam logic [ST_W-1:0] S_SQR_I   = {OP_SQR,     SUB_ISSUE};
  localparam logic [ST_W-1:0] S_SQR_W   = {OP_SQR,     SUB_WAIT};
  localparam logic [ST_W-1:0] S_MUL_I   = {OP_MUL,     SUB_ISSUE};
  localparam logic [ST_W-1:0] S_MUL_W   = {OP_MUL,     SUB_WAIT};
  localparam logic [ST_W-1:0] S_FINAL_I = {OP_FINAL,   SUB_ISSUE};
  localparam logic [ST_W-1:0] S_FINAL_W = {OP_FINAL,   SUB_WAIT};
  localparam logic [ST_W-1:0] S_FIN_OUT = {OP_FIN_OUT, SUB_ISSUE};

  // Operand-mux selects for the multiplier a/b inputs.
  localparam int unsigned SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_X_RR  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_SQR   = 2'd1;
  localparam logic [SEL_W-1:0] SEL_MUL   = 2'd2;
  localparam logic [SEL_W-1:0] SEL_FINAL = 2'd3;

endpackage

// File: rtl/mont_modexp_ctrl.sv
// Sequencer computing x^e mod m with a Montgomery multiplier: domain-in,
// constant-time square-and-multiply-always over every exponent bit, domain-out.
module mont_modexp_ctrl
  import mont_modexp_ctrl_pkg::*;
#(
  parameter int unsigned WID  = DEF_WID,
  parameter int unsigned EWID = DEF_EWID,
  parameter int unsigned ECW  = DEF_ECW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WID-1:0]  x,
  input  logic [EWID-1:0] e,
  input  logic [WID-1:0]  m,
  input  logic [WID-1:0]  rr,
  input  logic [WID-1:0]  one_m,
  output logic            busy,
  output logic            done,
  output logic [WID-1:0]  result,
  output logic            mp_start,
  output logic [WID-1:0]  mp_a,
  output logic [WID-1:0]  mp_b,
  output logic [WID-1:0]  mp_m,
  input  logic [WID-1:0]  mp_r,
  input  logic            mp_vld
);

  logic [ST_W-1:0]  state, state_nxt;
  logic [WID-1:0]   acc, acc_nxt;
  logic [WID-1:0]   xm, xm_nxt;
  logic [WID-1:0]   tmp;
  logic [EWID-1:0]  e_r, e_nxt;
  logic [ECW-1:0]   eidx, eidx_nxt;
  logic             busy_nxt, done_nxt, mp_start_nxt;
  logic [WID-1:0]   result_nxt, mp_a_nxt, mp_b_nxt, mp_m_nxt;
  logic [SEL_W-1:0] sel;
  logic             ld_ops;

  // MUL result; only committed to acc when the exponent bit is set.
  assign tmp = mp_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, operand selection and register-next computation.
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    xm_nxt       = xm;
    e_nxt        = e_r;
    eidx_nxt     = eidx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    result_nxt   = result;
    mp_start_nxt = 1'b0;
    mp_a_nxt     = mp_a;
    mp_b_nxt     = mp_b;
    mp_m_nxt     = mp_m;
    sel          = SEL_X_RR;
    ld_ops       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          busy_nxt  = 1'b1;
          e_nxt     = e;
          acc_nxt   = one_m;
          xm_nxt    = '0;
          eidx_nxt  = ECW'(EWID - 1);
          mp_m_nxt  = m;
          sel       = SEL_X_RR;
          ld_ops    = 1'b1;
        end
      end
      // Operands were captured on the accept edge; launch the conversion.
      S_LOAD: begin
        state_nxt    = S_CONV_I;
        mp_start_nxt = 1'b1;
      end
      S_CONV_I: state_nxt = S_CONV_W;
      S_CONV_W: begin
        if (mp_vld) begin
          xm_nxt       = mp_r;
          sel          = SEL_SQR;
          ld_ops       = 1'b1;
          mp_start_nxt = 1'b1;
          state_nxt    = S_SQR_I;
        end
      end
      S_SQR_I: state_nxt = S_SQR_W;
      S_SQR_W: begin
        if (mp_vld) begin
          acc_nxt      = mp_r;
          sel          = SEL_MUL;
          ld_ops       = 1'b1;
          mp_start_nxt = 1'b1;
          state_nxt    = S_MUL_I;
        end
      end
      S_MUL_I: state_nxt = S_MUL_W;
      S_MUL_W: begin
        if (mp_vld) begin
          if (e_r[eidx]) acc_nxt = tmp;
          ld_ops       = 1'b1;
          mp_start_nxt = 1'b1;
          if (eidx == '0) begin
            sel       = SEL_FINAL;
            state_nxt = S_FINAL_I;
          end else begin
            eidx_nxt  = eidx - ECW'(1);
            sel       = SEL_SQR;
            state_nxt = S_SQR_I;
          end
        end
      end
      S_FINAL_I: state_nxt = S_FINAL_W;
      S_FINAL_W: begin
        if (mp_vld) begin
          result_nxt = mp_r;
          done_nxt   = 1'b1;
          state_nxt  = S_FIN_OUT;
        end
      end
      S_FIN_OUT: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase

    // Operand mux; uses the freshly updated acc/xm so the next op issues
    // in the cycle right after the capture.
    if (ld_ops) begin
      case (sel)
        SEL_X_RR: begin
          mp_a_nxt = x;
          mp_b_nxt = rr;
        end
        SEL_SQR: begin
          mp_a_nxt = acc_nxt;
          mp_b_nxt = acc_nxt;
        end
        SEL_MUL: begin
          mp_a_nxt = acc_nxt;
          mp_b_nxt = xm_nxt;
        end
        default: begin
          mp_a_nxt = acc_nxt;
          mp_b_nxt = WID'(1);
        end
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      xm       <= '0;
      e_r      <= '0;
      eidx     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mp_start <= 1'b0;
      mp_a     <= '0;
      mp_b     <= '0;
      mp_m     <= '0;
    end else begin
      acc      <= acc_nxt;
      xm       <= xm_nxt;
      e_r      <= e_nxt;
      eidx     <= eidx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      result   <= result_nxt;
      mp_start <= mp_start_nxt;
      mp_a     <= mp_a_nxt;
      mp_b     <= mp_b_nxt;
      mp_m     <= mp_m_nxt;
    end
  end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl: a small 4-bit instance with directed vectors and
// a 256-bit instance against a plain modular-exponent model, each driving a
// behavioural Montgomery multiplier.
module tb_mont_modexp_ctrl;

  localparam int unsigned SW = 4, SE = 4, SC = 2, S_TMP = 3;
  localparam int unsigned BW = 256, BE = 16, BC = 4, B_TMP = 2;
  localparam int S_LAT = (2 * SE + 2) * (1 + S_TMP) + 2;
  localparam int B_LAT = (2 * BE + 2) * (1 + B_TMP) + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Montgomery product a*b*2^-w mod mm, bit-serial halving form.
  function automatic logic [511:0] mont(input logic [511:0] a, input logic [511:0] b,
                                        input logic [511:0] mm, input int w);
    logic [767:0] t;
    t = 768'(a) * 768'(b);
    for (int i = 0; i < w; i++) begin
      if (t[0]) t = t + 768'(mm);
      t = t >> 1;
    end
    if (t >= 768'(mm)) t = t - 768'(mm);
    return 512'(t);
  endfunction

  // Reference x^e mod m with ordinary modular arithmetic.
  function automatic logic [255:0] ref_modexp(input logic [255:0] xv, input logic [15:0] ev,
                                              input logic [255:0] mm);
    logic [511:0] r;
    r = 512'(1);
    for (int i = 15; i >= 0; i--) begin
      r = (r * r) % 512'(mm);
      if (ev[i]) r = (r * 512'(xv)) % 512'(mm);
    end
    return 256'(r);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- small instance ----------------
  logic           s_start;
  logic [SW-1:0]  s_x, s_m, s_rr, s_one, s_result, s_mp_a, s_mp_b, s_mp_m, s_mp_r, s_pend;
  logic [SE-1:0]  s_e;
  logic           s_busy, s_done, s_mp_start, s_mp_vld;
  int             s_cnt;

  mont_modexp_ctrl #(.WID(SW), .EWID(SE), .ECW(SC)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .x(s_x), .e(s_e), .m(s_m), .rr(s_rr),
    .one_m(s_one), .busy(s_busy), .done(s_done), .result(s_result),
    .mp_start(s_mp_start), .mp_a(s_mp_a), .mp_b(s_mp_b), .mp_m(s_mp_m),
    .mp_r(s_mp_r), .mp_vld(s_mp_vld)
  );

  // Multiplier model: vld S_TMP cycles after the start pulse.
  always @(posedge clk) begin
    if (rst) begin
      s_cnt <= 0; s_mp_vld <= 1'b0; s_mp_r <= '0;
    end else begin
      s_mp_vld <= 1'b0;
      if (s_mp_start) begin
        s_cnt  <= S_TMP - 1;
        s_pend <= SW'(mont(512'(s_mp_a), 512'(s_mp_b), 512'(s_mp_m), SW));
      end else if (s_cnt != 0) begin
        s_cnt <= s_cnt - 1;
        if (s_cnt == 1) begin s_mp_vld <= 1'b1; s_mp_r <= s_pend; end
      end
    end
  end

  // Handshake monitor: pulse/done counts, operand stability, no vld in ISSUE.
  logic [SW-1:0] s_sa, s_sb, s_sm;
  bit s_track = 1'b0, s_moved = 1'b0;
  int s_pulses = 0, s_dones = 0;
  always @(negedge clk) begin
    if (s_mp_vld) chk("s_vld_in_issue", 512'(s_mp_start), 512'(0));
    if (s_done) s_dones++;
    if (s_mp_start) begin
      s_pulses++;
      s_sa = s_mp_a; s_sb = s_mp_b; s_sm = s_mp_m;
      s_track = 1'b1; s_moved = 1'b0;
      chk("s_mp_m", 512'(s_mp_m), 512'(13));
    end else if (s_track) begin
      if (s_mp_a != s_sa || s_mp_b != s_sb || s_mp_m != s_sm) s_moved = 1'b1;
      if (s_mp_vld) begin
        chk("s_op_stable", 512'(s_moved), 512'(0));
        s_track = 1'b0;
      end
    end
  end

  task automatic s_run(input logic [SW-1:0] xv, input logic [SE-1:0] ev, input int inj,
                       input bit late_start, output logic [SW-1:0] res, output int lat);
    @(negedge clk);
    s_x = xv; s_e = ev; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; lat = 1;
    chk("s_busy_after_start", 512'(s_busy), 512'(1));
    while (!s_done && lat < 2000) begin
      if (lat == inj) begin s_x = 4'd5; s_start = 1'b1; end
      else s_start = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!s_done) chk("s_done_timeout", 512'(0), 512'(1));
    chk("s_busy_in_done", 512'(s_busy), 512'(1));
    res = s_result;
    s_start = late_start; s_x = 4'd11;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_busy_after_done", 512'(s_busy), 512'(0));
  endtask

  // ---------------- 256-bit instance ----------------
  logic           b_start;
  logic [BW-1:0]  b_x, b_m, b_rr, b_one, b_result, b_mp_a, b_mp_b, b_mp_m, b_mp_r, b_pend;
  logic [BE-1:0]  b_e;
  logic           b_busy, b_done, b_mp_start, b_mp_vld;
  int             b_cnt;

  mont_modexp_ctrl #(.WID(BW), .EWID(BE), .ECW(BC)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .x(b_x), .e(b_e), .m(b_m), .rr(b_rr),
    .one_m(b_one), .busy(b_busy), .done(b_done), .result(b_result),
    .mp_start(b_mp_start), .mp_a(b_mp_a), .mp_b(b_mp_b), .mp_m(b_mp_m),
    .mp_r(b_mp_r), .mp_vld(b_mp_vld)
  );

  always @(posedge clk) begin
    if (rst) begin
      b_cnt <= 0; b_mp_vld <= 1'b0; b_mp_r <= '0;
    end else begin
      b_mp_vld <= 1'b0;
      if (b_mp_start) begin
        b_cnt  <= B_TMP - 1;
        b_pend <= BW'(mont(512'(b_mp_a), 512'(b_mp_b), 512'(b_mp_m), BW));
      end else if (b_cnt != 0) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) begin b_mp_vld <= 1'b1; b_mp_r <= b_pend; end
      end
    end
  end

  logic [BW-1:0] b_sa, b_sb, b_sm;
  bit b_track = 1'b0, b_moved = 1'b0;
  always @(negedge clk) begin
    if (b_mp_vld) chk("b_vld_in_issue", 512'(b_mp_start), 512'(0));
    if (b_mp_start) begin
      b_sa = b_mp_a; b_sb = b_mp_b; b_sm = b_mp_m;
      b_track = 1'b1; b_moved = 1'b0;
    end else if (b_track) begin
      if (b_mp_a != b_sa || b_mp_b != b_sb || b_mp_m != b_sm) b_moved = 1'b1;
      if (b_mp_vld) begin
        chk("b_op_stable", 512'(b_moved), 512'(0));
        b_track = 1'b0;
      end
    end
  end

  task automatic b_run(output logic [BW-1:0] res, output int lat);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; lat = 1;
    while (!b_done && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    if (!b_done) chk("b_done_timeout", 512'(0), 512'(1));
    res = b_result;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [SW-1:0] sres;
    logic [BW-1:0] bres, bexp;
    logic [511:0]  t;
    int lat, d0, p0, n, k;

    rst = 1'b1;
    s_start = 1'b0; s_x = '0; s_e = '0; s_m = 4'd13; s_rr = 4'd9; s_one = 4'd3;
    b_start = 1'b0; b_x = '0; b_e = '0; b_m = 256'd3; b_rr = '0; b_one = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 512'(s_busy), 512'(0));
    chk("rst_done", 512'(s_done), 512'(0));
    chk("rst_mp_start", 512'(s_mp_start), 512'(0));
    chk("rst_result", 512'(s_result), 512'(0));
    chk("rst_mp_a", 512'(s_mp_a), 512'(0));
    chk("rst_mp_b", 512'(s_mp_b), 512'(0));
    chk("rst_mp_m", 512'(s_mp_m), 512'(0));
    rst = 1'b0;

    // 2^5 mod 13 = 6, ten multiplier ops, one done pulse
    d0 = s_dones; p0 = s_pulses;
    s_run(4'd2, 4'd5, 0, 1'b0, sres, lat);
    repeat (3) @(negedge clk);
    chk("x2_e5_result", 512'(sres), 512'(6));
    chk("x2_e5_dones", 512'(s_dones - d0), 512'(1));
    chk("x2_e5_pulses", 512'(s_pulses - p0), 512'(10));
    chk("x2_e5_latency", 512'(lat), 512'(S_LAT));

    s_run(4'd7, 4'd0, 0, 1'b0, sres, lat);
    chk("x7_e0_result", 512'(sres), 512'(1));
    chk("e0000_latency", 512'(lat), 512'(S_LAT));
    s_run(4'd2, 4'd15, 0, 1'b0, sres, lat);
    chk("x2_e15_result", 512'(sres), 512'(8));
    chk("e1111_latency", 512'(lat), 512'(S_LAT));
    s_run(4'd0, 4'd3, 0, 1'b0, sres, lat);
    chk("x0_e3_result", 512'(sres), 512'(0));
    s_run(4'd12, 4'd2, 0, 1'b0, sres, lat);
    chk("x12_e2_result", 512'(sres), 512'(1));

    // mid-run start with x=5 must not disturb 3^6 mod 13 = 1 (5^6 mod 13 = 12)
    d0 = s_dones;
    s_run(4'd3, 4'd6, 10, 1'b0, sres, lat);
    repeat (3) @(negedge clk);
    chk("midstart_result", 512'(sres), 512'(1));
    chk("midstart_dones", 512'(s_dones - d0), 512'(1));

    // start in the done cycle is dropped: 4^3 mod 13 = 12, then idle
    d0 = s_dones;
    s_run(4'd4, 4'd3, 0, 1'b1, sres, lat);
    repeat (60) @(negedge clk);
    chk("doneStart_result", 512'(sres), 512'(12));
    chk("doneStart_dones", 512'(s_dones - d0), 512'(1));
    chk("doneStart_idle", 512'(s_busy), 512'(0));

    // reset during the third WAIT
    d0 = s_dones;
    @(negedge clk);
    s_x = 4'd2; s_e = 4'd5; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0; k = 0;
    while (n < 3 && k < 500) begin
      @(negedge clk);
      k++;
      if (s_mp_start) n++;
    end
    chk("rst3_reached", 512'(n), 512'(3));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst3_busy", 512'(s_busy), 512'(0));
    chk("rst3_mp_start", 512'(s_mp_start), 512'(0));
    chk("rst3_done", 512'(s_done), 512'(0));
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst3_no_done", 512'(s_dones - d0), 512'(0));
    s_run(4'd2, 4'd5, 0, 1'b0, sres, lat);
    chk("after_rst_result", 512'(sres), 512'(6));

    // 256-bit randomised vectors, odd modulus with top bit set
    for (int v = 0; v < 50; v++) begin
      b_m   = rnd256() | {1'b1, 254'd0, 1'b1};
      t     = (512'(1) << 256) % 512'(b_m);
      b_one = BW'(t);
      b_rr  = BW'((512'(b_one) * 512'(b_one)) % 512'(b_m));
      b_x   = (v == 1) ? '0 : BW'(512'(rnd256()) % 512'(b_m));
      b_e   = (v == 0) ? '0 : ((v == 1) ? 16'h8001 : 16'($urandom));
      bexp  = ref_modexp(b_x, b_e, b_m);
      b_run(bres, lat);
      chk($sformatf("b_result_%0d", v), 512'(bres), 512'(bexp));
      chk($sformatf("b_latency_%0d", v), 512'(lat), 512'(B_LAT));
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
